// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage with IF/ID register, stall hold and branch redirect/flush.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    output logic                 if_valid,
    output logic [31:0]          if_instr,
    output logic [31:0]          if_pc,
    output logic [6:0]           opcode,
    output logic [15:0]          fetch_count
);
    typedef enum logic [1:0] {IDLE, FETCH, STALLED} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic        req;
    logic        xfer;

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH: begin
                req = !(stall && if_valid);
                if (stall && if_valid) state_nxt = STALLED;
            end
            STALLED: if (!stall) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
        if (branch_taken) state_nxt = FETCH;
    end

    assign xfer           = req && imem.imem_ready;
    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;
    assign opcode         = if_instr[6:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            if_instr    <= NOP_INSTR;
            if_pc       <= 32'h0;
            if_valid    <= 1'b0;
            fetch_count <= 16'h0;
        end else begin
            state <= state_nxt;
            // A redirect squashes whatever completes this cycle, uncounted.
            if (branch_taken) begin
                pc       <= {branch_target[31:2], 2'b00};
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end else if (req) begin
                if (xfer) begin
                    if_instr    <= imem.imem_rdata;
                    if_pc       <= pc;
                    if_valid    <= 1'b1;
                    pc          <= pc + 32'd4;
                    fetch_count <= fetch_count + 16'd1;
                end else begin
                    if_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized run vs. a reference model.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1, stall = 1'b0, br = 1'b0, ready = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic [31:0] sp_addr = 32'hFFFF_FFF0, sp_word = 32'h0, key = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic [6:0]  opcode;
    logic [15:0] fetch_count;

    logic        rst2 = 1'b1, ready2 = 1'b0;
    logic        if_valid2;
    logic [31:0] if_instr2, if_pc2;
    logic [6:0]  opcode2;
    logic [15:0] fetch_count2;

    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == sp_addr) ? sp_word : (a ^ key);
    endfunction

    fetch_stage_if bus ();
    fetch_stage_if bus2 ();
    assign bus.imem_ready  = ready;
    assign bus.imem_rdata  = mem(bus.imem_addr);
    assign bus2.imem_ready = ready2;
    assign bus2.imem_rdata = bus2.imem_addr;

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem(bus), .stall(stall), .branch_taken(br),
        .branch_target(tgt), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .opcode(opcode), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst2), .imem(bus2), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(32'h0), .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2),
        .opcode(opcode2), .fetch_count(fetch_count2)
    );

    // Reference model: 0 = first cycle after reset, 1 = fetching, 2 = holding for downstream.
    int          m_st;
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_valid;
    logic [15:0] m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_st <= 0; m_pc <= 32'h0; m_instr <= NOP; m_ipc <= 32'h0; m_valid <= 1'b0; m_cnt <= 16'h0;
        end else if (br) begin
            m_st <= 1; m_pc <= tgt & ~32'h3; m_valid <= 1'b0; m_instr <= NOP;
        end else if (m_st == 0) begin
            m_st <= 1;
        end else if (m_st == 2) begin
            if (!stall) m_st <= 1;
        end else if (stall && m_valid) begin
            m_st <= 2;
        end else if (ready) begin
            m_instr <= mem(m_pc); m_ipc <= m_pc; m_valid <= 1'b1; m_pc <= m_pc + 32'd4; m_cnt <= m_cnt + 16'd1;
        end else begin
            m_valid <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; br = 1'b0; stall = 1'b0; ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tick();
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
        checks++; if (if_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        checks++; if (if_instr !== NOP) begin fails++; $display("FAIL reset_instr: got %h want %h", if_instr, NOP); end
        checks++; if (opcode !== 7'b0010011) begin fails++; $display("FAIL reset_opcode: got %b want 0010011", opcode); end
        checks++; if (if_pc !== 32'h0 || fetch_count !== 16'h0) begin
            fails++; $display("FAIL reset_pc_cnt: got %h/%h want 0/0", if_pc, fetch_count); end
    endtask

    task automatic test_stream();
        rst = 1'b0; ready = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL stream_idle_req: got %b want 0", bus.imem_req); end
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || if_valid !== 1'b0) begin
            fails++; $display("FAIL stream_first: req %b addr %h valid %b want 1 0 0", bus.imem_req, bus.imem_addr, if_valid); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (bus.imem_addr !== 32'(4*i) || if_pc !== 32'(4*(i-1)) || if_instr !== 32'(4*(i-1)) ||
                if_valid !== 1'b1 || fetch_count !== 16'(i)) begin
                fails++; $display("FAIL stream_%0d: addr %h pc %h instr %h valid %b cnt %0d want %h %h %h 1 %0d",
                    i, bus.imem_addr, if_pc, if_instr, if_valid, fetch_count, 4*i, 4*(i-1), 4*(i-1), i);
            end
        end
    endtask

    task automatic test_ready_gap();
        do_reset();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
                fails++; $display("FAIL gap_req_%0d: req %b addr %h want 1 4", i, bus.imem_req, bus.imem_addr); end
            tick();
            checks++; if (if_valid !== 1'b0 || fetch_count !== 16'd1 || bus.imem_addr !== 32'h4) begin
                fails++; $display("FAIL gap_hold_%0d: valid %b cnt %0d addr %h want 0 1 4", i, if_valid, fetch_count, bus.imem_addr); end
        end
        ready = 1'b1;
        tick();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || bus.imem_addr !== 32'h8 || fetch_count !== 16'd2) begin
            fails++; $display("FAIL gap_resume: valid %b pc %h addr %h cnt %0d want 1 4 8 2", if_valid, if_pc, bus.imem_addr, fetch_count); end
    endtask

    task automatic test_stall();
        sp_addr = 32'h8; sp_word = 32'h0050_0093;
        do_reset();
        ready = 1'b1;
        repeat (3) tick();
        checks++; if (if_instr !== 32'h0050_0093 || opcode !== 7'b0010011 || if_pc !== 32'h8) begin
            fails++; $display("FAIL stall_word: instr %h op %b pc %h want 00500093 0010011 8", if_instr, opcode, if_pc); end
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.imem_req !== 1'b0 || if_instr !== 32'h0050_0093 || if_valid !== 1'b1 || fetch_count !== 16'd3) begin
                fails++; $display("FAIL stall_hold_%0d: req %b instr %h valid %b cnt %0d want 0 00500093 1 3",
                    i, bus.imem_req, if_instr, if_valid, fetch_count); end
            tick();
        end
        stall = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b0 || if_instr !== 32'h0050_0093) begin
            fails++; $display("FAIL stall_release: req %b instr %h want 0 00500093", bus.imem_req, if_instr); end
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== if_pc + 32'd4 || bus.imem_addr !== 32'hC) begin
            fails++; $display("FAIL stall_resume: req %b addr %h want 1 c", bus.imem_req, bus.imem_addr); end
        sp_addr = 32'hFFFF_FFF0;
    endtask

    task automatic test_branch();
        do_reset();
        ready = 1'b1;
        repeat (4) tick();
        br = 1'b1; tgt = 32'h102;
        #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
            fails++; $display("FAIL br_pre: req %b addr %h want 1 10", bus.imem_req, bus.imem_addr); end
        tick();
        br = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || if_valid !== 1'b0 ||
                      if_instr !== NOP || fetch_count !== 16'd4) begin
            fails++; $display("FAIL br_redirect: req %b addr %h valid %b instr %h cnt %0d want 1 100 0 13 4",
                bus.imem_req, bus.imem_addr, if_valid, if_instr, fetch_count); end
        tick();
        checks++; if (if_pc !== 32'h100 || if_valid !== 1'b1 || fetch_count !== 16'd5) begin
            fails++; $display("FAIL br_target_fetch: pc %h valid %b cnt %0d want 100 1 5", if_pc, if_valid, fetch_count); end
        // redirect again, this time from the held state
        stall = 1'b1;
        tick();
        br = 1'b1; tgt = 32'h102;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL br_stalled_req: got %b want 0", bus.imem_req); end
        tick();
        br = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || if_valid !== 1'b0 ||
                      if_instr !== NOP || fetch_count !== 16'd5) begin
            fails++; $display("FAIL br_from_stall: req %b addr %h valid %b instr %h cnt %0d want 1 100 0 13 5",
                bus.imem_req, bus.imem_addr, if_valid, if_instr, fetch_count); end
        stall = 1'b0;
    endtask

    task automatic test_rst_branch();
        do_reset();
        ready = 1'b1;
        repeat (5) tick();
        rst = 1'b1; br = 1'b1; tgt = 32'h200;
        tick();
        rst = 1'b0; br = 1'b0;
        checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || if_valid !== 1'b0 ||
                      if_instr !== NOP || if_pc !== 32'h0 || fetch_count !== 16'h0) begin
            fails++; $display("FAIL rst_over_branch: req %b addr %h valid %b instr %h pc %h cnt %0d want 0 0 0 13 0 0",
                bus.imem_req, bus.imem_addr, if_valid, if_instr, if_pc, fetch_count); end
    endtask

    task automatic test_random();
        logic exp_req;
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 63) == 0);
            ready = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 2) == 0);
            br    = ($urandom_range(0, 15) == 0);
            tgt   = $urandom;
            key   = $urandom;
            #1;
            exp_req = (m_st == 1) && !(stall && m_valid);
            checks++;
            if ({bus.imem_req, bus.imem_addr, if_valid, if_instr, if_pc, fetch_count} !==
                {exp_req, m_pc, m_valid, m_instr, m_ipc, m_cnt}) begin
                fails++;
                $display("FAIL random_%0d: req %b addr %h valid %b instr %h pc %h cnt %h want %b %h %b %h %h %h",
                    i, bus.imem_req, bus.imem_addr, if_valid, if_instr, if_pc, fetch_count,
                    exp_req, m_pc, m_valid, m_instr, m_ipc, m_cnt);
            end
            tick();
        end
        rst = 1'b0; br = 1'b0; stall = 1'b0; key = 32'h0;
    endtask

    task automatic test_wrap();
        rst2 = 1'b0;
        tick();
        checks++; if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'hFFFF_FFFC) begin
            fails++; $display("FAIL wrap_start: req %b addr %h want 1 fffffffc", bus2.imem_req, bus2.imem_addr); end
        ready2 = 1'b1;
        tick();
        checks++; if (bus2.imem_addr !== 32'h0 || if_pc2 !== 32'hFFFF_FFFC || fetch_count2 !== 16'd1) begin
            fails++; $display("FAIL wrap_pc: addr %h pc %h cnt %0d want 0 fffffffc 1", bus2.imem_addr, if_pc2, fetch_count2); end
        repeat (65534) tick();
        checks++; if (fetch_count2 !== 16'hFFFF) begin
            fails++; $display("FAIL wrap_cnt_max: got %h want ffff", fetch_count2); end
        tick();
        checks++; if (fetch_count2 !== 16'h0 || if_valid2 !== 1'b1 || if_pc2 !== 32'h0003_FFF8) begin
            fails++; $display("FAIL wrap_cnt: cnt %h valid %b pc %h want 0 1 0003fff8", fetch_count2, if_valid2, if_pc2); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ready_gap();
        test_stall();
        test_branch();
        test_rst_branch();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
